// File: rtl/core_types_pkg.sv
// Shared types and constants for the data-memory responder.
package core_types_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  func3;
        logic        is_store;
    } dmem_req_t;

    typedef struct packed {
        logic [31:0] memOut;
        logic        hold;
        logic        done;
        logic        err;
    } dmem_out_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only know the signed encodings; loads also accept the unsigned ones.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        if (is_store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: write enables/replication for stores, extraction and
// extension for loads, and alignment check for the access size.
module dmem_lane_align
    import core_types_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_sh,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rdata[{addr_lo, 3'b000} +: 8];
    assign rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Decode size from func3[1:0]; func3[2] selects zero extension on loads.
    always_comb begin
        byte_en   = '0;
        wdata_sh  = '0;
        load_data = '0;
        misalign  = 1'b0;
        case (func3[1:0])
            2'b00: begin
                byte_en   = 4'b0001 << addr_lo;
                wdata_sh  = {4{wdata[7:0]}};
                load_data = func3[2] ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
            end
            2'b01: begin
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_sh  = {2{wdata[15:0]}};
                load_data = func3[2] ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
                misalign  = addr_lo[0];
            end
            2'b10: begin
                byte_en   = 4'b1111;
                wdata_sh  = wdata;
                load_data = rdata;
                misalign  = |addr_lo;
            end
            default: begin
                byte_en = '0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, stalls the pipeline for
// WAIT_STATES+1 cycles, then presents a one-cycle response.
module dmem_responder
    import core_types_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Rmem,
    input  logic        Wmem,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        hold,
    output logic        done,
    output logic [31:0] memOut,
    output logic        err
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept;

    dmem_req_t   req_q, req_in, acc_req;
    logic        both_q, both_in, acc_both;

    logic [31:0] mem [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic [31:0] rdata;

    logic [3:0]  byte_en;
    logic [31:0] wdata_sh;
    logic [31:0] load_data;
    logic        misalign;

    logic        legal;
    logic        enter_resp;
    logic        acc_err;
    logic        acc_wr;
    logic [31:0] load_val;
    logic [31:0] memOut_q;
    logic        err_q;
    dmem_out_t   out_s;
    logic        unused_addr_hi;

    assign req_in  = '{addr: addr, wdata: wdata, func3: func3, is_store: Wmem};
    assign both_in = Rmem & Wmem;

    // With no wait states the access happens on the accepting edge, so the
    // live request must feed the datapath while in IDLE.
    assign acc_req  = (state_q == IDLE) ? req_in  : req_q;
    assign acc_both = (state_q == IDLE) ? both_in : both_q;

    assign idx   = acc_req.addr[IDX_W+1:2];
    assign rdata = mem[idx];
    assign unused_addr_hi = ^acc_req.addr[31:IDX_W+2];

    dmem_lane_align u_align (
        .func3     (acc_req.func3),
        .addr_lo   (acc_req.addr[1:0]),
        .wdata     (acc_req.wdata),
        .rdata     (rdata),
        .byte_en   (byte_en),
        .wdata_sh  (wdata_sh),
        .load_data (load_data),
        .misalign  (misalign)
    );

    assign legal      = f3_legal(acc_req.func3, acc_req.is_store);
    assign enter_resp = (state_d == RESP) && (state_q != RESP);
    assign acc_err    = !legal || misalign || acc_both;
    assign acc_wr     = enter_resp && acc_req.is_store && legal && !misalign && !rst;
    assign load_val   = (!acc_req.is_store && legal && !misalign) ? load_data : '0;

    // Next-state and wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Rmem || Wmem) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0)
                    state_d = RESP;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output bundle: hold covers the accepting cycle and every wait cycle.
    always_comb begin
        out_s        = '0;
        out_s.hold   = ((state_q == IDLE) && (Rmem || Wmem)) || (state_q == WAIT);
        out_s.done   = (state_q == RESP);
        out_s.memOut = memOut_q;
        out_s.err    = err_q;
    end

    assign memOut = out_s.memOut;
    assign hold   = out_s.hold;
    assign done   = out_s.done;
    assign err    = out_s.err;

    // State, counter and registered response; response regs self-clear outside RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            memOut_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            memOut_q <= enter_resp ? load_val : '0;
            err_q    <= enter_resp ? acc_err : 1'b0;
        end
    end

    // Capture the request on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q  <= '0;
            both_q <= 1'b0;
        end else if (accept) begin
            req_q  <= req_in;
            both_q <= both_in;
        end
    end

    // Storage: not reset; byte-enabled write on the edge entering RESP.
    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (acc_wr && byte_en[b])
                mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
    end

endmodule
